// File: rtl/cmd_uart_responder.sv
// cmd_uart_responder: remote-link UART endpoint.
// Receives two bytes (high first) and presents them as a 16-bit command with a
// ready flag. Serializes an 8-bit response byte back to the remote.
// Optional macro CMD_TIMEOUT_EN: drop a pending high byte when the low byte
// does not arrive within TIMEOUT_CYC clocks.
module cmd_uart_responder #(
  parameter int BAUD_CNT    = 2604,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic        resp_sent
);

  // Wide enough for the 1.5-bit initial delay of the receiver.
  localparam int CW = $clog2(2 * BAUD_CNT);

  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_BREAK} rx_st_t;
  typedef enum logic       {WAIT_HI, WAIT_LO}           asm_st_t;
  typedef enum logic       {TX_IDLE, TX_XMIT}           tx_st_t;

  // ---------------- receiver ----------------
  logic          rx_ff1_q, rx_ff2_q;
  rx_st_t        rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shft_q;
  logic          byte_rdy_q, frm_err_q;
  logic          start_det;

  assign start_det = (rx_st_q == RX_IDLE) && !rx_ff2_q;

  // Synchronize RX, then sample mid-bit: first data sample 1.5 bit times after
  // the start edge, every bit time after that; the 9th sample is the stop bit.
  // After a framing error the line may still be low, so wait for it to return
  // high before re-arming start detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1_q   <= 1'b1;
      rx_ff2_q   <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shft_q  <= '0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_ff1_q   <= RX;
      rx_ff2_q   <= rx_ff1_q;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
      case (rx_st_q)
        RX_IDLE: if (!rx_ff2_q) begin
          rx_st_q  <= RX_RECV;
          rx_cnt_q <= CW'(BAUD_CNT + BAUD_CNT / 2 - 1);
          rx_bit_q <= '0;
        end
        RX_RECV: if (rx_cnt_q == '0) begin
          rx_cnt_q <= CW'(BAUD_CNT - 1);
          if (rx_bit_q == 4'd8) begin
            if (rx_ff2_q) begin
              byte_rdy_q <= 1'b1;
              rx_st_q    <= RX_IDLE;
            end else begin
              frm_err_q  <= 1'b1;
              rx_st_q    <= RX_BREAK;
            end
          end else begin
            rx_shft_q <= {rx_ff2_q, rx_shft_q[7:1]};
            rx_bit_q  <= rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q - CW'(1);
        end
        default: if (rx_ff2_q) rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- command assembly ----------------
  asm_st_t    asm_st_q;
  logic [7:0] hi_q;
  logic [15:0] cmd_q;
  logic       cmd_rdy_q;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q;
`endif

  // Pair bytes into a command; cmd only changes on a complete pair. A set of
  // cmd_rdy in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_st_q  <= WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      if (clr_cmd_rdy || (start_det && asm_st_q == WAIT_HI)) cmd_rdy_q <= 1'b0;
      if (frm_err_q) begin
        asm_st_q <= WAIT_HI;
      end else if (byte_rdy_q) begin
        if (asm_st_q == WAIT_HI) begin
          hi_q     <= rx_shft_q;
          asm_st_q <= WAIT_LO;
`ifdef CMD_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end else begin
          cmd_q     <= {hi_q, rx_shft_q};
          cmd_rdy_q <= 1'b1;
          asm_st_q  <= WAIT_HI;
        end
      end
`ifdef CMD_TIMEOUT_EN
      else if (asm_st_q == WAIT_LO) begin
        if (start_det)                          to_cnt_q <= '0;
        else if (to_cnt_q == TW'(TIMEOUT_CYC))  asm_st_q <= WAIT_HI;
        else                                    to_cnt_q <= to_cnt_q + TW'(1);
      end
`endif
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------- transmitter ----------------
  tx_st_t        tx_st_q;
  logic          tx_q;
  logic [8:0]    tx_shft_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;
  logic          resp_sent_q;

  // Start bit goes out the cycle after snd_resp; bit index 0 is the start bit,
  // 1..8 data, 9 the stop bit. Requests while busy are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q     <= TX_IDLE;
      tx_q        <= 1'b1;
      tx_shft_q   <= '0;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      case (tx_st_q)
        TX_IDLE: if (snd_resp) begin
          tx_shft_q   <= {1'b1, resp};
          tx_q        <= 1'b0;
          tx_cnt_q    <= CW'(BAUD_CNT - 1);
          tx_bit_q    <= '0;
          resp_sent_q <= 1'b0;
          tx_st_q     <= TX_XMIT;
        end
        default: if (tx_cnt_q == '0) begin
          if (tx_bit_q == 4'd9) begin
            tx_st_q     <= TX_IDLE;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b1;
          end else begin
            tx_q      <= tx_shft_q[0];
            tx_shft_q <= {1'b0, tx_shft_q[8:1]};
            tx_bit_q  <= tx_bit_q + 4'd1;
            tx_cnt_q  <= CW'(BAUD_CNT - 1);
          end
        end else begin
          tx_cnt_q <= tx_cnt_q - CW'(1);
        end
      endcase
    end
  end

  assign TX        = tx_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Directed bench for cmd_uart_responder with BAUD_CNT=16, TIMEOUT_CYC=500.
module tb_cmd_uart_responder;
  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst, RX, clr_cmd_rdy, snd_resp;
  logic [7:0]  resp;
  logic        TX, cmd_rdy, resp_sent;
  logic [15:0] cmd;
  int checks = 0;
  int errors = 0;
  logic [9:0]  fr;

  always #5 clk = ~clk;

  cmd_uart_responder #(.BAUD_CNT(BAUD), .TIMEOUT_CYC(500)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .snd_resp(snd_resp),
    .resp_sent(resp_sent)
  );

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one UART frame; called at a negedge, returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = stop;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
  endtask

  initial begin
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; snd_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    chk1("reset_tx", TX, 1'b1);
    chk16("reset_cmd", cmd, 16'h0000);
    chk1("reset_cmd_rdy", cmd_rdy, 1'b0);
    chk1("reset_resp_sent", resp_sent, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // basic command 0x3BF2
    send_byte(8'h3B, 1'b1);
    chk1("hi_only_rdy", cmd_rdy, 1'b0);
    chk16("hi_only_cmd", cmd, 16'h0000);
    send_byte(8'hF2, 1'b1);
    chk16("cmd_3bf2", cmd, 16'h3BF2);
    chk1("rdy_3bf2", cmd_rdy, 1'b1);
    repeat (20) @(negedge clk);
    chk1("rdy_hold", cmd_rdy, 1'b1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk1("rdy_cleared", cmd_rdy, 1'b0);

    // response 0xA5, second request mid-frame with different data
    resp = 8'hA5; snd_resp = 1'b1;
    @(negedge clk);
    snd_resp = 1'b0; resp = 8'h3C;
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < ((k == 0) ? 8 : BAUD); j++) begin
        @(negedge clk);
        snd_resp = (k == 4 && j == 0);
      end
      chk1($sformatf("tx_bit%0d", k), TX, fr[k]);
    end
    repeat (7) @(negedge clk);
    chk1("resp_sent_early", resp_sent, 1'b0);
    @(negedge clk);
    chk1("resp_sent_160", resp_sent, 1'b1);
    chk1("tx_idle_after", TX, 1'b1);

    // framing error byte is discarded
    repeat (16) @(negedge clk);
    send_byte(8'h00, 1'b0);
    repeat (40) @(negedge clk);
    chk16("ferr_cmd_kept", cmd, 16'h3BF2);
    chk1("ferr_no_rdy", cmd_rdy, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk16("cmd_1234", cmd, 16'h1234);
    chk1("rdy_1234", cmd_rdy, 1'b1);

    // clear coinciding with low-byte completion: set wins
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_byte(8'h56, 1'b1);
    fork
      send_byte(8'h78, 1'b1);
      begin
        repeat (155) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    join
    chk16("cmd_5678", cmd, 16'h5678);
    chk1("set_wins", cmd_rdy, 1'b1);

    // long gap between high and low byte
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_byte(8'hAB, 1'b1);
    repeat (600) @(negedge clk);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
`ifdef CMD_TIMEOUT_EN
    chk16("timeout_cmd", cmd, 16'hCDEF);
`else
    chk16("no_timeout_cmd", cmd, 16'hABCD);
`endif

    // new request clears resp_sent; reset mid-frame on both sides
    repeat (20) @(negedge clk);
    resp = 8'h81; snd_resp = 1'b1;
    @(negedge clk);
    snd_resp = 1'b0;
    chk1("resp_sent_clr", resp_sent, 1'b0);
    repeat (30) @(negedge clk);
    RX = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1; RX = 1'b1;
    @(negedge clk);
    chk1("mid_rst_tx", TX, 1'b1);
    chk1("mid_rst_resp_sent", resp_sent, 1'b0);
    chk16("mid_rst_cmd", cmd, 16'h0000);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk1("tx_aborted", TX, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk16("cmd_0000", cmd, 16'h0000);
    chk1("rdy_0000", cmd_rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
